// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory responder.
// Holds the FSM state encoding, the default RAM address width and the fetch address helper.
// No logic of its own; imported by mem_ctrl.
package mem_ctrl_pkg;

   // Default RAM byte-address width; request address bits above this are dropped.
   localparam int RAM_AW_DEF = 17;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [7:0]  ZERO_BYTE = 8'h00;
   localparam logic        TRUE_V    = 1'b1;
   localparam logic        FALSE_V   = 1'b0;

   // IDLE/DATA plus one state per fetch beat; IF4 is the done-pulse cycle.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DATA = 3'd1,
      ST_IF0  = 3'd2,
      ST_IF1  = 3'd3,
      ST_IF2  = 3'd4,
      ST_IF3  = 3'd5,
      ST_IF4  = 3'd6
   } state_e;

   // Full 32-bit byte address of fetch beat idx; the caller truncates to the RAM width,
   // so a fetch that runs off the top of the RAM wraps to address 0.
   function automatic logic [31:0] fetch_byte_addr(input logic [31:0] base, input logic [1:0] idx);
      return base + {30'd0, idx};
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between a data port (pass-through) and an instruction port (4-byte fetch).
// Data port: combinational, same cycle. Fetch: 5 cycles from accept to if_done_o pulse.
// Data port is never stalled and preempts any fetch in progress; the fetch restarts from byte 0 afterwards.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int RAM_AW = RAM_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_inst_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [7:0]        mem_wdata_i,
   output logic [7:0]        mem_rdata_o,
   output logic [RAM_AW-1:0] ram_a_o,
   output logic [7:0]        ram_dout_o,
   output logic              ram_wr_o,
   input  logic [7:0]        ram_din_i
);

   state_e      state_q, state_d;
   logic [23:0] buf_q, buf_d;     // bytes 0..2 of the fetch in progress
   logic [31:0] inst_q, inst_d;   // last assembled word, held between done pulses

   logic        fetch_go;         // a fetch beat address goes out this cycle (if the data port is quiet)
   logic [1:0]  fetch_idx;        // which byte of the word that beat addresses
   logic [31:0] fetch_sum;
   logic        capture;          // fetch still alive: requester holding on, data port quiet

   assign fetch_sum = fetch_byte_addr(if_addr_i, fetch_idx);
   assign capture   = if_req_i & ~mem_req_i;

   // High address bits are dropped on purpose; keep them visibly consumed.
   logic unused_hi;
   assign unused_hi = ^{mem_addr_i[31:RAM_AW], fetch_sum[31:RAM_AW]};

   // Next state and fetch beat selection; the data port overrides everything.
   always_comb begin
      state_d   = state_q;
      fetch_go  = FALSE_V;
      fetch_idx = 2'd0;
      case (state_q)
         ST_IDLE: begin
            if (if_req_i) begin
               state_d  = ST_IF0;
               fetch_go = TRUE_V;
            end
         end
         ST_DATA: begin
            // The cycle the data port lets go is spent returning to IDLE.
            state_d = ST_IDLE;
         end
         ST_IF0: begin
            if (if_req_i) begin
               state_d   = ST_IF1;
               fetch_go  = TRUE_V;
               fetch_idx = 2'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IF1: begin
            if (if_req_i) begin
               state_d   = ST_IF2;
               fetch_go  = TRUE_V;
               fetch_idx = 2'd2;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IF2: begin
            if (if_req_i) begin
               state_d   = ST_IF3;
               fetch_go  = TRUE_V;
               fetch_idx = 2'd3;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IF3: begin
            state_d = if_req_i ? ST_IF4 : ST_IDLE;
         end
         ST_IF4: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (mem_req_i) begin
         state_d  = ST_DATA;
         fetch_go = FALSE_V;
      end
   end

   // Byte capture: RAM data arrives one cycle after its address, so IFk holds byte k.
   // Any abort clears the partial word so a restart cannot reuse stale bytes.
   always_comb begin
      buf_d  = buf_q;
      inst_d = inst_q;
      case (state_q)
         ST_IF0:  buf_d = capture ? {buf_q[23:8], ram_din_i} : 24'd0;
         ST_IF1:  buf_d = capture ? {buf_q[23:16], ram_din_i, buf_q[7:0]} : 24'd0;
         ST_IF2:  buf_d = capture ? {ram_din_i, buf_q[15:0]} : 24'd0;
         ST_IF3: begin
            if (capture) begin
               inst_d = {ram_din_i, buf_q};
            end
            buf_d = 24'd0;
         end
         default: begin
         end
      endcase
   end

   // RAM port mux: data port wins in the same cycle; otherwise the current fetch beat, else idle zeros.
   always_comb begin
      ram_a_o     = '0;
      ram_wr_o    = FALSE_V;
      ram_dout_o  = ZERO_BYTE;
      mem_rdata_o = ZERO_BYTE;
      if (rst) begin
         ram_a_o = '0;
      end else if (mem_req_i) begin
         ram_a_o     = mem_addr_i[RAM_AW-1:0];
         ram_wr_o    = mem_we_i;
         ram_dout_o  = mem_wdata_i;
         mem_rdata_o = ram_din_i;
      end else if (fetch_go) begin
         ram_a_o = fetch_sum[RAM_AW-1:0];
      end
   end

   assign if_done_o = (state_q == ST_IF4) & ~rst;
   assign if_inst_o = inst_q;

   // State and fetch buffers; synchronous reset discards any fetch in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         buf_q   <= 24'd0;
         inst_q  <= ZERO_WORD;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         inst_q  <= inst_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: RAM model, reference memory, scoreboard queues and an independent monitor.
// Stimulus pushes expected fetch words, write beats and read bytes; the monitor pops on DUT activity.
// Directed cases first, then randomized mixes of fetches, data accesses, preemptions and flushes.
module tb_mem_ctrl;

   localparam int          AW   = 17;
   localparam logic [31:0] MASK = 32'h0001_FFFF;

   typedef struct {
      logic [16:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'd0;
   logic [31:0] if_inst_o;
   logic        if_done_o;
   logic        mem_req_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [31:0] mem_addr_i = 32'd0;
   logic [7:0]  mem_wdata_i = 8'd0;
   logic [7:0]  mem_rdata_o;
   logic [16:0] ram_a_o;
   logic [7:0]  ram_dout_o;
   logic        ram_wr_o;
   logic [7:0]  ram_din_i;

   mem_ctrl #(.RAM_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o), .if_done_o(if_done_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
      .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
   );

   always #5 clk = ~clk;

   // Byte RAM with one-cycle read latency; a preload channel fills it without going through the DUT.
   logic [7:0]  ram     [0:(1<<AW)-1];
   logic [7:0]  ref_mem [0:(1<<AW)-1];
   logic        pl_en = 1'b0;
   logic [16:0] pl_addr = 17'd0;
   logic [7:0]  pl_dat = 8'd0;

   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_dat;
      else if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
      ram_din_i <= ram[ram_a_o];
   end

   int total = 0;
   int bad = 0;
   int wr_seen = 0;
   logic [31:0] exp_inst[$];
   wr_t         exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic        rd_tag = 1'b0;
   logic        prev_tag_q = 1'b0;

   always @(posedge clk) prev_tag_q <= rd_tag;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [16:0] ra(input logic [31:0] a);
      return a[16:0];
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return {ref_mem[ra(a + 32'd3)], ref_mem[ra(a + 32'd2)], ref_mem[ra(a + 32'd1)], ref_mem[ra(a)]};
   endfunction

   // Random address in a preloaded window; random high bits must be ignored by the DUT.
   function automatic logic [31:0] rnd_addr();
      logic [31:0] lo;
      logic [31:0] hi;
      if ($urandom_range(0, 1) == 0) lo = 32'h100 + 32'($urandom_range(0, 60));
      else lo = (32'h1FFF0 + 32'($urandom_range(0, 28))) & MASK;
      hi = $urandom & 32'hFFFE_0000;
      return hi | lo;
   endfunction

   // Monitor: pops expectations whenever the DUT shows a result.
   always @(negedge clk) begin
      if (!rst) begin
         if (if_done_o) begin
            if (exp_inst.size() == 0) chk("unexp_done", 32'(if_done_o), 32'd0);
            else chk("inst", if_inst_o, exp_inst.pop_front());
         end
         if (ram_wr_o) begin
            wr_seen++;
            if (exp_wr.size() == 0) chk("unexp_wr", 32'(ram_wr_o), 32'd0);
            else begin
               wr_t e;
               e = exp_wr.pop_front();
               chk("wr_addr", 32'(ram_a_o), 32'(e.a));
               chk("wr_data", 32'(ram_dout_o), 32'(e.d));
            end
         end
         if (prev_tag_q && exp_rd.size() != 0) chk("rdata", 32'(mem_rdata_o), 32'(exp_rd.pop_front()));
         if (!mem_req_i) chk("quiet_outs", 32'({ram_wr_o, ram_dout_o, mem_rdata_o}), 32'd0);
      end
   end

   task automatic preload(input logic [16:0] a, input logic [7:0] d);
      pl_en = 1'b1;
      pl_addr = a;
      pl_dat = d;
      ref_mem[a] = d;
      step();
      pl_en = 1'b0;
   endtask

   // n data-port beats starting at addr; reads hold the request one extra cycle for the last byte.
   task automatic data_access(input bit we, input logic [31:0] addr, input int n, input logic [31:0] wd);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         logic [7:0] b;
         a = addr + 32'(i);
         b = wd[8*i +: 8];
         mem_req_i = 1'b1;
         mem_we_i = we;
         mem_addr_i = a;
         if (we) begin
            mem_wdata_i = b;
            rd_tag = 1'b0;
            exp_wr.push_back('{a: ra(a), d: b});
            ref_mem[ra(a)] = b;
         end else begin
            mem_wdata_i = 8'($urandom_range(0, 255));
            rd_tag = 1'b1;
            exp_rd.push_back(ref_mem[ra(a)]);
         end
         step();
      end
      if (!we) begin
         rd_tag = 1'b0;
         mem_addr_i = $urandom;
         step();
      end
      mem_req_i = 1'b0;
      mem_we_i = 1'b0;
      rd_tag = 1'b0;
      mem_addr_i = $urandom;
      mem_wdata_i = 8'($urandom_range(0, 255));
   endtask

   // Waits (bounded) for if_done_o, checking latency and optionally the fetch beat addresses.
   task automatic wait_done(input int lat, input int off, input bit chka, input logic [31:0] base,
                            input bit keep, input string nm);
      int k;
      bit seen;
      k = 0;
      seen = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk);
         if (chka && k >= off && k < off + 4)
            chk({nm, "_addr"}, 32'(ram_a_o), (base + 32'(k - off)) & MASK);
         if (if_done_o) seen = 1'b1;
         else begin
            step();
            k++;
         end
      end
      chk({nm, "_lat"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(lat));
      step();
      if (!keep) if_req_i = 1'b0;
   endtask

   task automatic flush(input logic [31:0] a, input int d, input string nm);
      int cnt;
      cnt = 0;
      if_req_i = 1'b1;
      if_addr_i = a;
      repeat (d) step();
      if_req_i = 1'b0;
      repeat (7) begin
         @(negedge clk);
         if (if_done_o) cnt++;
         step();
      end
      chk(nm, 32'(cnt), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] a2;
      int wr0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_inst", if_inst_o, 32'd0);
      chk("rst_ram_a", 32'(ram_a_o), 32'd0);
      chk("rst_ctl", 32'({if_done_o, ram_wr_o, ram_dout_o, mem_rdata_o}), 32'd0);
      step();

      for (int i = 0; i < 64; i++) preload(17'(32'h100 + 32'(i)), 8'($urandom_range(0, 255)));
      for (int i = 0; i < 32; i++) preload(ra(32'h1FFF0 + 32'(i)), 8'($urandom_range(0, 255)));

      // Known-word fetch.
      preload(17'h100, 8'h13);
      preload(17'h101, 8'h05);
      preload(17'h102, 8'h10);
      preload(17'h103, 8'h00);
      step();
      if_req_i = 1'b1;
      if_addr_i = 32'h100;
      exp_inst.push_back(32'h0010_0513);
      wait_done(5, 0, 1'b1, 32'h100, 1'b0, "fetch1");

      // Byte-serial store then load of 0xDEADBEEF.
      step();
      wr0 = wr_seen;
      data_access(1'b1, 32'h200, 4, 32'hDEAD_BEEF);
      step();
      chk("sw_wr_cycles", 32'(wr_seen - wr0), 32'd4);
      chk("sw_ram", {ram[17'h203], ram[17'h202], ram[17'h201], ram[17'h200]}, 32'hDEAD_BEEF);
      data_access(1'b0, 32'h200, 4, 32'd0);
      step();

      // Contention: both requests rise together in IDLE.
      a = 32'h120;
      if_req_i = 1'b1;
      if_addr_i = a;
      data_access(1'b0, 32'h104, 2, 32'd0);
      exp_inst.push_back(exp_word(a));
      wait_done(6, 1, 1'b1, a, 1'b0, "contend");

      // Preemption in IF2 by a byte load.
      step();
      a = 32'h108;
      if_req_i = 1'b1;
      if_addr_i = a;
      repeat (3) step();
      data_access(1'b0, 32'h130, 1, 32'd0);
      exp_inst.push_back(exp_word(a));
      wait_done(6, 1, 1'b1, a, 1'b0, "preempt");

      // Flush in IF1.
      step();
      flush(32'h110, 2, "flush_if1");

      // Reset in IF3.
      step();
      if_req_i = 1'b1;
      if_addr_i = 32'h114;
      repeat (4) step();
      rst = 1'b1;
      if_req_i = 1'b0;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_if3_inst", if_inst_o, 32'd0);
      chk("rst_if3_ram_a", 32'(ram_a_o), 32'd0);
      chk("rst_if3_ctl", 32'({if_done_o, ram_wr_o, ram_dout_o, mem_rdata_o}), 32'd0);
      step();

      // Wrap-around at the top of the RAM.
      step();
      a = 32'h0001_FFFE;
      if_req_i = 1'b1;
      if_addr_i = a;
      exp_inst.push_back(exp_word(a));
      wait_done(5, 0, 1'b1, a, 1'b0, "wrap");

      // Back-to-back fetches with if_req_i held.
      step();
      a = rnd_addr();
      a2 = rnd_addr();
      if_req_i = 1'b1;
      if_addr_i = a;
      exp_inst.push_back(exp_word(a));
      wait_done(5, 0, 1'b1, a, 1'b1, "b2b_a");
      if_addr_i = a2;
      exp_inst.push_back(exp_word(a2));
      wait_done(5, 0, 1'b1, a2, 1'b0, "b2b_b");

      // Randomized mix.
      for (int n = 0; n < 150; n++) begin
         int op;
         op = int'($urandom_range(0, 5));
         step();
         a = rnd_addr();
         case (op)
            0, 1: begin
               if_req_i = 1'b1;
               if_addr_i = a;
               exp_inst.push_back(exp_word(a));
               wait_done(5, 0, 1'b1, a, 1'b0, "rnd_fetch");
            end
            2: data_access(1'b1, a, int'($urandom_range(1, 4)), $urandom);
            3: data_access(1'b0, a, int'($urandom_range(1, 4)), 32'd0);
            4: begin
               if_req_i = 1'b1;
               if_addr_i = a;
               repeat (int'($urandom_range(1, 4))) step();
               data_access(1'($urandom_range(0, 1)), rnd_addr(), int'($urandom_range(1, 4)), $urandom);
               exp_inst.push_back(exp_word(a));
               wait_done(6, 1, 1'b1, a, 1'b0, "rnd_preempt");
            end
            default: flush(a, int'($urandom_range(1, 4)), "rnd_flush");
         endcase
      end

      repeat (5) step();
      chk("inst_left", 32'(exp_inst.size()), 32'd0);
      chk("wr_left", 32'(exp_wr.size()), 32'd0);
      chk("rd_left", 32'(exp_rd.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
